// File: rtl/uart_tx_pkg.sv
// Shared types for the FIFO-fed UART transmitter (fifo_uart_tx).
// UART_PARITY_EN selects the even-parity frame format.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port between the 8-bit sync FIFO (slave) and fifo_uart_tx (master).
// FIFO read data is registered: fifo_data is valid the cycle after fifo_rd.
interface fifo_uart_tx_if;

  logic                                fifo_rd;
  logic                                fifo_empty;
  logic [uart_tx_pkg::DATA_BITS-1:0]   fifo_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: wraps at CLKS_PER_BIT-1, held at zero by clear.
// bit_end flags the last cycle of a bit, bit_near_end the cycle before it.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_near_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end      = (cnt == LAST);
  assign bit_near_end = (cnt == NEAR);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a sync FIFO and sends each as an 8N1/8N2 UART frame, LSB first.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bit_idx;
  logic                 stop_cnt;
  logic                 bit_end;
  logic                 bit_near_end;
  logic                 timer_clear;
  logic                 start_ok;
`ifdef UART_PARITY_EN
  logic                 parity_bit;
`endif

  // Timer runs only while a bit is on the line, so START always begins at count 0.
  assign timer_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);
  assign start_ok    = en && !fifo.fifo_empty;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (timer_clear),
    .bit_end      (bit_end),
    .bit_near_end (bit_near_end)
  );

  // NOTE: the shift register is reset as well, so a byte popped before an
  // aborting reset cannot linger and leak into a later frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tx           <= 1'b1;
      fifo.fifo_rd <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      shift        <= '0;
      bit_idx      <= '0;
      stop_cnt     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      fifo.fifo_rd <= 1'b0;
      tx_done      <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_ok) begin
            state        <= FETCH;
            fifo.fifo_rd <= 1'b1;
            busy         <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift    <= fifo.fifo_data;
`ifdef UART_PARITY_EN
          parity_bit <= ^fifo.fifo_data;
`endif
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= {1'b0, shift[DATA_BITS-1:1]};
              tx      <= shift[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          // Registered pulse: raised one cycle early so it lands in the final cycle.
          if (bit_near_end && stop_cnt == STOP_LAST) tx_done <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == STOP_LAST) begin
              if (start_ok) begin
                state        <= FETCH;
                fifo.fifo_rd <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
